// File: rtl/control_frecuencia_pkg.sv
// Shared constants, state encoding and step-to-code table for the frequency sequencer.
`timescale 1ns/1ps
package control_frecuencia_pkg;

  localparam int unsigned DIV_W_DEF  = 11;
  localparam int unsigned CODE_W_DEF = 8;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned STEP_MAX   = 7;
  localparam int unsigned DIV_RESET  = 1667;
  localparam int unsigned DIV_MIN    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Frequency code presented to memoria_div for each step index.
  function automatic logic [7:0] step_to_code(input logic [STEP_W-1:0] s);
    logic [7:0] code;
    case (s)
      3'd0:    code = 8'd30;
      3'd1:    code = 8'd50;
      3'd2:    code = 8'd75;
      3'd3:    code = 8'd100;
      3'd4:    code = 8'd125;
      3'd5:    code = 8'd150;
      3'd6:    code = 8'd175;
      default: code = 8'd200;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_frecuencia_if.sv
// Button/enable inputs, lookup handshake and generator outputs of control_frecuencia.
`timescale 1ns/1ps
interface control_frecuencia_if
  import control_frecuencia_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF
);
  logic              btn_up;
  logic              btn_down;
  logic              enable;
  logic [DIV_W-1:0]  numdiv;
  logic [CODE_W-1:0] num;
  logic [STEP_W-1:0] step;
  logic              sq_out;
  logic              tick;
  logic              busy;

  modport master (
    output btn_up, btn_down, enable, numdiv,
    input  num, step, sq_out, tick, busy
  );

  modport slave (
    input  btn_up, btn_down, enable, numdiv,
    output num, step, sq_out, tick, busy
  );
endinterface

// File: rtl/control_frecuencia_detector_flanco.sv
// Rising-edge detector for a synchronous, debounced button level.
`timescale 1ns/1ps
module control_frecuencia_detector_flanco (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_c_o
);
  logic prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= sig_i;
  end

  assign rise_c_o = sig_i & ~prev_q;
endmodule

// File: rtl/control_frecuencia.sv
// Step sequencer driving memoria_div plus a glitch-free divided square-wave generator.
`timescale 1ns/1ps
module control_frecuencia
  import control_frecuencia_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  control_frecuencia_if.slave  bus
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CODE_W-1:0] num_q, num_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              sq_q, sq_d;
  logic              tick_q, tick_d;
  logic              chg_q, chg_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;

  logic              up_c, dn_c;
  logic              term_c;
  logic [DIV_W-1:0]  div_new_c;

  control_frecuencia_detector_flanco u_det_up (
    .clock    (clock),
    .reset    (reset),
    .sig_i    (bus.btn_up),
    .rise_c_o (up_c)
  );

  control_frecuencia_detector_flanco u_det_dn (
    .clock    (clock),
    .reset    (reset),
    .sig_i    (bus.btn_down),
    .rise_c_o (dn_c)
  );

  assign term_c    = (cnt_q == div_q - DIV_W'(1));
  assign div_new_c = (bus.numdiv < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.numdiv;

  // Step sequencing; simultaneous edges cancel, saturated presses are ignored.
  always_comb begin
    step_d = step_q;
    chg_d  = 1'b0;
    if (up_c && !dn_c && (step_q != STEP_W'(STEP_MAX))) begin
      step_d = step_q + STEP_W'(1);
      chg_d  = 1'b1;
    end else if (dn_c && !up_c && (step_q != STEP_W'(0))) begin
      step_d = step_q - STEP_W'(1);
      chg_d  = 1'b1;
    end
    num_d = CODE_W'(step_to_code(step_d));
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    tick_d  = 1'b0;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sq_d  = 1'b0;
        if (bus.enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        div_d   = div_new_c;
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (term_c) begin
          cnt_d  = '0;
          sq_d   = ~sq_q;
          tick_d = 1'b1;
          // Divisor only swaps at a half-period boundary so no period is truncated.
          if (pend_q) begin
            div_d  = div_new_c;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!bus.enable) begin
      state_d = ST_IDLE;
      div_d   = div_q;
      cnt_d   = '0;
      sq_d    = 1'b0;
      tick_d  = 1'b0;
      pend_d  = pend_q;
    end
    // Lookup output is valid one edge after the step change; re-arm wins over clear.
    if (chg_q) pend_d = 1'b1;
    busy_d = pend_d | (state_d == ST_LOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      num_q   <= CODE_W'(30);
      div_q   <= DIV_W'(DIV_RESET);
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      tick_q  <= 1'b0;
      chg_q   <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      num_q   <= num_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      tick_q  <= tick_d;
      chg_q   <= chg_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.num    = num_q;
  assign bus.step   = step_q;
  assign bus.sq_out = sq_q;
  assign bus.tick   = tick_q;
  assign bus.busy   = busy_q;

endmodule
